ervp_cmp_lane_packer: RTL and testbench

//  - Upstream feeder for the 4-lane compare-reduce tree.
//  - Takes a scalar valid/ready stream and packs it into 4-lane groups with a valid bit per lane.
//  - Groups close early on s_last, leaving partial groups with unused lanes marked invalid.
//  - m_ready connects to the tree's enable input; m_lane_valid/m_lane_data feed its lane valid/data inputs.

---
 rtl/ervp_cmp_pkg.sv | 28 ++
 rtl/ervp_cmp_group_slot.sv | 66 ++++++
 rtl/ervp_cmp_lane_packer.sv | 119 +++++++++++
 tb/tb_ervp_cmp_lane_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ervp_cmp_pkg.sv
// ----------------------------------------------------------------------------
// ervp_cmp_pkg
//   Shared definitions for the 4-lane compare-reduce path.
//   - CMP_NUM_LANE     : lanes per group (fixed at 4)
//   - CMP_BW_LANE_IDX  : width of a lane index
//   - lane_prefix_mask : contiguous low-order valid mask for a lane count
// ----------------------------------------------------------------------------
package ervp_cmp_pkg;

    localparam int CMP_NUM_LANE    = 4;
    localparam int CMP_BW_LANE_IDX = 2;

    // num_used is a lane count (0..4), so it needs one bit more than a lane index.
    // Returns a mask with bits [num_used-1:0] set, e.g. 3 -> 4'b0111.
    function automatic logic [CMP_NUM_LANE-1:0] lane_prefix_mask(
        input logic [CMP_BW_LANE_IDX:0] num_used
    );
        logic [CMP_NUM_LANE-1:0] mask;
        mask = '0;
        for (int i = 0; i < CMP_NUM_LANE; i++) begin
            if (i < int'(num_used)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ervp_cmp_group_slot.sv
// ----------------------------------------------------------------------------
// ervp_cmp_group_slot
//   Output holding register for one packed lane group.
//   It loads a new group when the slot is free, holds it while the
//   downstream stalls, and empties itself once the group is consumed.
//   Ports:
//     clk, rstnn    clock / asynchronous active-low reset
//     clear         synchronous flush back to the empty state
//     load          present a group this cycle (taken only when out_free)
//     in_valid      per-lane valid of the presented group
//     in_data       lane data of the presented group, lane i at [BW*(i+1)-1 -: BW]
//     in_last       presented group was closed by s_last
//     out_free      slot can take a group on this edge (~m_valid | m_ready)
//     m_valid, m_ready, m_lane_valid, m_lane_data, m_last   downstream side
// ----------------------------------------------------------------------------
module ervp_cmp_group_slot
    import ervp_cmp_pkg::*;
#(
    parameter int BW_DATA = 1
) (
    input  logic                              clk,
    input  logic                              rstnn,
    input  logic                              clear,
    input  logic                              load,
    input  logic [CMP_NUM_LANE-1:0]           in_valid,
    input  logic [CMP_NUM_LANE*BW_DATA-1:0]   in_data,
    input  logic                              in_last,
    output logic                              out_free,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [CMP_NUM_LANE-1:0]           m_lane_valid,
    output logic [CMP_NUM_LANE*BW_DATA-1:0]   m_lane_data,
    output logic                              m_last
);

    assign out_free = ~m_valid | m_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            m_valid      <= 1'b0;
            m_lane_valid <= '0;
            m_lane_data  <= '0;
            m_last       <= 1'b0;
        end else if (clear) begin
            m_valid      <= 1'b0;
            m_lane_valid <= '0;
            m_lane_data  <= '0;
            m_last       <= 1'b0;
        end else if (load && out_free) begin
            // Also covers back-to-back: consume the old group and load the next one.
            m_valid      <= 1'b1;
            m_lane_valid <= in_valid;
            m_lane_data  <= in_data;
            m_last       <= in_last;
        end else if (m_valid && m_ready) begin
            // Drain. Data is zeroed too so the outputs read zero whenever m_valid=0.
            m_valid      <= 1'b0;
            m_lane_valid <= '0;
            m_lane_data  <= '0;
            m_last       <= 1'b0;
        end
    end

endmodule

// File: rtl/ervp_cmp_lane_packer.sv
// ----------------------------------------------------------------------------
// ervp_cmp_lane_packer
//   Packs a scalar valid/ready stream into 4-lane groups for the compare-reduce
//   tree. A group closes when it is full or when a word arrives with s_last.
//   A closed group is handed to the output slot on the same edge if the slot
//   is free. Otherwise the group is parked in the fill buffer (pend) and the
//   upstream is stalled until the slot frees up.
//   Ports:
//     clk, rstnn    clock / asynchronous active-low reset
//     clear         synchronous flush of all buffered state
//     s_valid, s_ready, s_data, s_last          scalar input stream
//     m_valid, m_ready, m_lane_valid, m_lane_data, m_last   packed group output
// ----------------------------------------------------------------------------
module ervp_cmp_lane_packer
    import ervp_cmp_pkg::*;
#(
    parameter int BW_DATA = 1
) (
    input  logic                              clk,
    input  logic                              rstnn,
    input  logic                              clear,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [BW_DATA-1:0]                s_data,
    input  logic                              s_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [CMP_NUM_LANE-1:0]           m_lane_valid,
    output logic [CMP_NUM_LANE*BW_DATA-1:0]   m_lane_data,
    output logic                              m_last
);

    logic [CMP_NUM_LANE-1:0][BW_DATA-1:0] fill_data;
    logic [CMP_NUM_LANE-1:0]              fill_valid;
    logic                                 fill_last;
    logic [CMP_BW_LANE_IDX-1:0]           cnt;
    logic                                 pend;

    logic                                 out_free;
    logic                                 accept;
    logic                                 complete;
    logic                                 load_pend;
    logic                                 load_new;
    logic [CMP_NUM_LANE-1:0][BW_DATA-1:0] grp_data;
    logic [CMP_NUM_LANE-1:0]              grp_valid;
    logic [CMP_NUM_LANE-1:0]              slot_valid;
    logic [CMP_NUM_LANE*BW_DATA-1:0]      slot_data;
    logic                                 slot_last;

    // A parked group blocks the upstream until the output slot takes it.
    assign s_ready   = ~pend;
    assign accept    = s_valid & s_ready;
    assign complete  = accept & ((cnt == CMP_BW_LANE_IDX'(CMP_NUM_LANE - 1)) | s_last);
    assign load_pend = pend & out_free;
    assign load_new  = complete & out_free;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        grp_data  = fill_data;
        grp_valid = fill_valid;
        if (accept) begin
            grp_data[cnt] = s_data;
            grp_valid     = lane_prefix_mask({1'b0, cnt} + 3'd1);
        end
    end

    // When pend is set, no word can be accepted, so the slot input is the parked group.
    assign slot_valid = pend ? fill_valid : grp_valid;
    assign slot_data  = pend ? fill_data  : grp_data;
    assign slot_last  = pend ? fill_last  : s_last;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            fill_data  <= '0;
            fill_valid <= '0;
            fill_last  <= 1'b0;
            cnt        <= '0;
            pend       <= 1'b0;
        end else if (clear || load_pend || load_new) begin
            // Flush, or the group left for the slot: start again at lane 0.
            fill_data  <= '0;
            fill_valid <= '0;
            fill_last  <= 1'b0;
            cnt        <= '0;
            pend       <= 1'b0;
        end else if (accept) begin
            fill_data  <= grp_data;
            fill_valid <= grp_valid;
            if (complete) begin
                // Closed but the slot is busy: park the group and stall the upstream.
                fill_last <= s_last;
                cnt       <= '0;
                pend      <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    ervp_cmp_group_slot #(
        .BW_DATA (BW_DATA)
    ) u_slot (
        .clk          (clk),
        .rstnn        (rstnn),
        .clear        (clear),
        .load         (load_pend | load_new),
        .in_valid     (slot_valid),
        .in_data      (slot_data),
        .in_last      (slot_last),
        .out_free     (out_free),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_lane_valid (m_lane_valid),
        .m_lane_data  (m_lane_data),
        .m_last       (m_last)
    );

endmodule

// File: tb/tb_ervp_cmp_lane_packer.sv
// ----------------------------------------------------------------------------
// tb_ervp_cmp_lane_packer
//   Directed bench for the 4-lane packer with BW_DATA=8. Inputs change and
//   outputs are sampled 1 time unit after each rising edge. A whole group is
//   compared as {m_valid, m_last, m_lane_valid, m_lane_data}.
// ----------------------------------------------------------------------------
module tb_ervp_cmp_lane_packer;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_lane_valid;
    logic [31:0] m_lane_data;
    logic        m_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [37:0] grp;
    assign grp = {m_valid, m_last, m_lane_valid, m_lane_data};

    always #5 clk = ~clk;

    ervp_cmp_lane_packer #(.BW_DATA(BW)) dut (
        .clk          (clk),
        .rstnn        (rstnn),
        .clear        (clear),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_lane_valid (m_lane_valid),
        .m_lane_data  (m_lane_data),
        .m_last       (m_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstnn = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (grp !== 38'h0) $display("FAIL reset_outputs: got %h want %h", grp, 38'h0);
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready);
        else pass_cnt++;
        @(negedge clk);
        rstnn = 1'b1;
        step();
    endtask

    // Eight words 0x10..0x17 with s_last on the last: two full groups, no bubble.
    task automatic test_stream(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(i);
            s_last  = (i == 7);
            total_cnt++;
            if (s_ready !== 1'b1) $display("FAIL %s_s_ready_w%0d: got %b want 1", tag, i, s_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (i == 3) begin
                if (grp !== {1'b1, 1'b0, 4'hF, 32'h13121110})
                    $display("FAIL %s_group1: got %h want %h", tag, grp, {1'b1, 1'b0, 4'hF, 32'h13121110});
                else pass_cnt++;
            end else if (i == 7) begin
                if (grp !== {1'b1, 1'b1, 4'hF, 32'h17161514})
                    $display("FAIL %s_group2: got %h want %h", tag, grp, {1'b1, 1'b1, 4'hF, 32'h17161514});
                else pass_cnt++;
            end else begin
                if (m_valid !== 1'b0) $display("FAIL %s_idle_w%0d: got m_valid=%b want 0", tag, i, m_valid);
                else pass_cnt++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL %s_drain: got m_valid=%b want 0", tag, m_valid);
        else pass_cnt++;
    endtask

    task automatic test_partial();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'hA1; s_last = 1'b0;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL partial_early: got m_valid=%b want 0", m_valid);
        else pass_cnt++;
        s_data = 8'hA2; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (grp !== {1'b1, 1'b1, 4'b0011, 32'h0000A2A1})
            $display("FAIL partial_group: got %h want %h", grp, {1'b1, 1'b1, 4'b0011, 32'h0000A2A1});
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL partial_one_cycle: got m_valid=%b want 0", m_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h20 + 8'(i);
            s_last  = 1'b0;
            total_cnt++;
            if (s_ready !== 1'b1) $display("FAIL bp_s_ready_w%0d: got %b want 1", i, s_ready);
            else pass_cnt++;
            step();
            if (i == 3) begin
                total_cnt++;
                if (grp !== {1'b1, 1'b0, 4'hF, 32'h23222120})
                    $display("FAIL bp_group1_load: got %h want %h", grp, {1'b1, 1'b0, 4'hF, 32'h23222120});
                else pass_cnt++;
            end
        end
        s_valid = 1'b0;
        total_cnt++;
        if (s_ready !== 1'b0) $display("FAIL bp_pend_stall: got s_ready=%b want 0", s_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (grp !== {1'b1, 1'b0, 4'hF, 32'h23222120})
            $display("FAIL bp_group1_hold: got %h want %h", grp, {1'b1, 1'b0, 4'hF, 32'h23222120});
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b0) $display("FAIL bp_still_stalled: got s_ready=%b want 0", s_ready);
        else pass_cnt++;
        m_ready = 1'b1;
        step();
        total_cnt++;
        if (grp !== {1'b1, 1'b0, 4'hF, 32'h27262524})
            $display("FAIL bp_group2: got %h want %h", grp, {1'b1, 1'b0, 4'hF, 32'h27262524});
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL bp_s_ready_release: got %b want 1", s_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL bp_drain: got m_valid=%b want 0", m_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'h5C; s_last = 1'b1;
        step();
        total_cnt++;
        if (grp !== {1'b1, 1'b1, 4'b0001, 32'h0000005C})
            $display("FAIL b2b_first: got %h want %h", grp, {1'b1, 1'b1, 4'b0001, 32'h0000005C});
        else pass_cnt++;
        s_data = 8'h5D;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (grp !== {1'b1, 1'b1, 4'b0001, 32'h0000005D})
            $display("FAIL b2b_second: got %h want %h", grp, {1'b1, 1'b1, 4'b0001, 32'h0000005D});
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL b2b_drain: got m_valid=%b want 0", m_valid);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_data = 8'h30 + 8'(i); s_last = 1'b0;
            step();
        end
        total_cnt++;
        if (grp !== {1'b1, 1'b0, 4'hF, 32'h33323130})
            $display("FAIL clr_setup: got %h want %h", grp, {1'b1, 1'b0, 4'hF, 32'h33323130});
        else pass_cnt++;
        // A word offered during clear must be dropped.
        clear = 1'b1; s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
        step();
        clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (grp !== 38'h0) $display("FAIL clr_outputs: got %h want %h", grp, 38'h0);
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL clr_s_ready: got %b want 1", s_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL clr_word_dropped: got m_valid=%b want 0", m_valid);
        else pass_cnt++;
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'h40; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (grp !== {1'b1, 1'b1, 4'b0001, 32'h00000040})
            $display("FAIL clr_fresh_group: got %h want %h", grp, {1'b1, 1'b1, 4'b0001, 32'h00000040});
        else pass_cnt++;
        step();
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'h50 + 8'(i); s_last = 1'b0;
            step();
        end
        s_valid = 1'b0;
        total_cnt++;
        if (m_valid !== 1'b1) $display("FAIL arst_setup: got m_valid=%b want 1", m_valid);
        else pass_cnt++;
        #2;
        rstnn = 1'b0;
        #1;
        total_cnt++;
        if (grp !== 38'h0) $display("FAIL arst_outputs: got %h want %h", grp, 38'h0);
        else pass_cnt++;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL arst_s_ready: got %b want 1", s_ready);
        else pass_cnt++;
        @(negedge clk);
        rstnn = 1'b1;
        step();
        test_stream("post_arst");
    endtask

    initial begin
        test_reset();
        test_stream("stream");
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
